// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// Module : game_pkg
// Brief  : Shared state encoding, BCD limits and score helper for the math game.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARM     = 3'd1;
   localparam logic [2:0] PLAY    = 3'd2;
   localparam logic [2:0] CORRECT = 3'd3;
   localparam logic [2:0] MISS    = 3'd4;
   localparam logic [2:0] OVER    = 3'd5;

   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam logic [7:0] SCORE_MAX = 8'h99;

   // Two-digit BCD increment that sticks at 99 instead of wrapping.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == SCORE_MAX)
         return v;
      else if (v[3:0] == BCD_MAX)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_score_counter.sv
// ---------------------------------------------------------------------------
// Module : bcd_score_counter
// Brief  : Saturating 2-digit BCD score register with clear and increment.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_score_counter
   import game_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Clear,
   input  logic       Inc,
   output logic [3:0] Tens,
   output logic [3:0] Ones
);

   logic [7:0] r_score;

   always_ff @(posedge Clock) begin
      if (Reset || Clear)
         r_score <= 8'h00;
      else if (Inc)
         r_score <= bcd_inc(r_score);
   end

   assign Tens = r_score[7:4];
   assign Ones = r_score[3:0];

endmodule

`default_nettype wire

// File: rtl/round_controller.sv
// ---------------------------------------------------------------------------
// Module : round_controller
// Brief  : Round sequencer for the binary math game: drives the countdown
//          timer, judges answers, keeps BCD score, lives and flash feedback.
//          Macro ROUND_LIVES_EN enables multi-life play (LIVES lives).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module round_controller
   import game_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int FLASH_CYCLES = 4,
   parameter int MISS_CYCLES  = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Submit,
   input  logic       Correct,
   input  logic       TimeUp,
   output logic       TimerEnable,
   output logic       TimerReconfig,
   output logic       NewProblem,
   output logic [3:0] ScoreTens,
   output logic [3:0] ScoreOnes,
   output logic [1:0] Lives,
   output logic       Flash,
   output logic       GameOver
);

   localparam int c_HOLD_MAX = (FLASH_CYCLES > MISS_CYCLES) ? FLASH_CYCLES : MISS_CYCLES;
   localparam int c_CW       = $clog2(c_HOLD_MAX + 1);
   localparam logic [c_CW-1:0] c_FLASH_LOAD = c_CW'(FLASH_CYCLES - 1);
   localparam logic [c_CW-1:0] c_MISS_LOAD  = c_CW'(MISS_CYCLES - 1);

`ifdef ROUND_LIVES_EN
   localparam logic [1:0] c_LIVES_INIT = 2'(LIVES);
`else
   // Single-life play: the LIVES parameter has no effect on the start value.
   localparam logic [1:0] c_LIVES_INIT = (LIVES > 0) ? 2'd1 : 2'd1;
`endif

   logic [2:0]      r_state;
   logic [1:0]      r_lives;
   logic [c_CW-1:0] r_flash_cnt;
   logic            r_play_first;
   logic            w_hit;
   logic            w_start_game;

   assign w_hit        = (r_state == PLAY) && Submit && Correct;
   assign w_start_game = ((r_state == IDLE) || (r_state == OVER)) && Start;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_lives      <= c_LIVES_INIT;
         r_flash_cnt  <= '0;
         r_play_first <= 1'b0;
      end else begin
         r_play_first <= 1'b0;
         case (r_state)
            IDLE, OVER: begin
               if (Start) begin
                  r_state <= ARM;
                  r_lives <= c_LIVES_INIT;
               end
            end
            ARM: begin
               r_state      <= PLAY;
               r_play_first <= 1'b1;
            end
            PLAY: begin
               // A correct answer beats a simultaneous TimeUp; TimeUp is
               // masked while the timer is still reloading.
               if (Submit && Correct) begin
                  r_state     <= CORRECT;
                  r_flash_cnt <= c_FLASH_LOAD;
               end else if (Submit || (TimeUp && !r_play_first)) begin
                  r_state     <= MISS;
                  r_lives     <= r_lives - 2'd1;
                  r_flash_cnt <= c_MISS_LOAD;
               end
            end
            CORRECT: begin
               if (r_flash_cnt == '0)
                  r_state <= ARM;
               else
                  r_flash_cnt <= r_flash_cnt - 1'b1;
            end
            MISS: begin
               if (r_flash_cnt == '0)
                  r_state <= (r_lives == 2'd0) ? OVER : ARM;
               else
                  r_flash_cnt <= r_flash_cnt - 1'b1;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   bcd_score_counter u_score (
      .Clock (Clock),
      .Reset (Reset),
      .Clear (w_start_game),
      .Inc   (w_hit),
      .Tens  (ScoreTens),
      .Ones  (ScoreOnes)
   );

   assign TimerEnable   = (r_state == PLAY);
   assign TimerReconfig = (r_state == ARM);
   assign NewProblem    = (r_state == ARM);
   assign Flash         = (r_state == CORRECT) || (r_state == MISS);
   assign GameOver      = (r_state == OVER);
   assign Lives         = r_lives;

endmodule

`default_nettype wire

// File: tb/tb_round_controller.sv
// ---------------------------------------------------------------------------
// Module : tb_round_controller
// Brief  : Self-checking bench for round_controller against a score/lives model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_round_controller;

   localparam int c_F = 4;
   localparam int c_M = 4;
`ifdef ROUND_LIVES_EN
   localparam int c_L = 3;
`else
   localparam int c_L = 1;
`endif
   localparam int K_CORRECT = 0;
   localparam int K_WRONG   = 1;
   localparam int K_TIMEUP  = 2;
   localparam int K_COLLIDE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       Start, Submit, Correct, TimeUp;
   logic       TimerEnable, TimerReconfig, NewProblem, Flash, GameOver;
   logic [3:0] ScoreTens, ScoreOnes;
   logic [1:0] Lives;
   logic [14:0] w_obs;

   int n_checks = 0;
   int n_errors = 0;
   int m_score;
   int m_lives;
   bit m_over;

   round_controller #(.LIVES(3), .FLASH_CYCLES(c_F), .MISS_CYCLES(c_M)) dut (
      .Clock(clk), .Reset(rst), .Start(Start), .Submit(Submit), .Correct(Correct),
      .TimeUp(TimeUp), .TimerEnable(TimerEnable), .TimerReconfig(TimerReconfig),
      .NewProblem(NewProblem), .ScoreTens(ScoreTens), .ScoreOnes(ScoreOnes),
      .Lives(Lives), .Flash(Flash), .GameOver(GameOver)
   );

   always #5 clk = ~clk;

   assign w_obs = {TimerEnable, TimerReconfig, NewProblem, Flash, GameOver, Lives, ScoreTens, ScoreOnes};

   // Expected output vector from the model's score (decimal) and lives.
   function automatic logic [14:0] exp_vec(input logic te, input logic rc, input logic np,
                                           input logic fl, input logic go);
      return {te, rc, np, fl, go, 2'(m_lives), 4'(m_score / 10), 4'(m_score % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      Start = 1'b0; Submit = 1'b0; Correct = 1'b0; TimeUp = 1'b0;
   endtask

   task automatic start_game();
      Start = 1'b1;
      step();
      Start = 1'b0;
      m_score = 0; m_lives = c_L; m_over = 1'b0;
      n_checks++;
      if (w_obs !== exp_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
         n_errors++; $display("FAIL start_arm: got %h exp %h", w_obs, exp_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
      step();
      n_checks++;
      if (w_obs !== exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++; $display("FAIL start_play: got %h exp %h", w_obs, exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   // One round from inside PLAY: optional idle cycles, an event, the flash hold,
   // then either the next ARM/PLAY or OVER. Stray pulses are injected where
   // they must be dropped.
   task automatic do_round(input int kind, input int delay);
      bit hit;
      int n;
      for (int i = 0; i < delay; i++) begin
         Start = 1'($urandom_range(0, 1));
         Correct = 1'($urandom_range(0, 1));
         step();
         clear_inputs();
         n_checks++;
         if (w_obs !== exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_errors++; $display("FAIL play_wait: got %h exp %h", w_obs, exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         end
      end
      Submit  = (kind != K_TIMEUP);
      Correct = (kind == K_CORRECT) || (kind == K_COLLIDE);
      TimeUp  = (kind == K_TIMEUP) || (kind == K_COLLIDE);
      step();
      clear_inputs();
      hit = (kind == K_CORRECT) || (kind == K_COLLIDE);
      if (hit) m_score = (m_score < 99) ? m_score + 1 : 99;
      else     m_lives = m_lives - 1;
      n = hit ? c_F : c_M;
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (w_obs !== exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            n_errors++; $display("FAIL flash[%0d]: got %h exp %h", i, w_obs, exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
         end
         Submit = 1'($urandom_range(0, 1));
         Correct = 1'($urandom_range(0, 1));
         Start = 1'($urandom_range(0, 1));
         step();
         clear_inputs();
      end
      if (m_lives == 0) begin
         m_over = 1'b1;
         n_checks++;
         if (w_obs !== exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_errors++; $display("FAIL over: got %h exp %h", w_obs, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
         end
      end else begin
         n_checks++;
         if (w_obs !== exp_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
            n_errors++; $display("FAIL rearm: got %h exp %h", w_obs, exp_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
         end
         step();
         n_checks++;
         if (w_obs !== exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_errors++; $display("FAIL replay: got %h exp %h", w_obs, exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      m_score = 0; m_lives = c_L; m_over = 1'b0;
      repeat (3) step();
      n_checks++;
      if (w_obs !== exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++; $display("FAIL reset_held: got %h exp %h", w_obs, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      rst = 1'b0;
      Submit = 1'b1; Correct = 1'b1;
      step();
      clear_inputs();
      n_checks++;
      if (w_obs !== exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++; $display("FAIL idle_drop_submit: got %h exp %h", w_obs, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_carry();
      for (int i = 0; i < 10; i++) do_round(K_CORRECT, $urandom_range(0, 3));
      n_checks++;
      if ({ScoreTens, ScoreOnes} !== 8'h10) begin
         n_errors++; $display("FAIL carry: got %h exp 10", {ScoreTens, ScoreOnes});
      end
   endtask

   task automatic test_saturation();
      while (m_score < 99) do_round(K_CORRECT, 0);
      do_round(K_CORRECT, 1);
      n_checks++;
      if ({ScoreTens, ScoreOnes} !== 8'h99) begin
         n_errors++; $display("FAIL saturate: got %h exp 99", {ScoreTens, ScoreOnes});
      end
   endtask

   task automatic test_lives();
      while (!m_over) do_round(K_TIMEUP, $urandom_range(1, 3));
      start_game();
   endtask

   task automatic test_collision();
      TimeUp = 1'b1;
      step();
      TimeUp = 1'b0;
      n_checks++;
      if (w_obs !== exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++; $display("FAIL first_cycle_timeup: got %h exp %h", w_obs, exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      do_round(K_COLLIDE, 0);
      do_round(K_COLLIDE, 2);
   endtask

   task automatic test_wrong_submit();
      while (!m_over) do_round(K_WRONG, $urandom_range(0, 2));
   endtask

   task automatic test_random();
      for (int g = 0; g < 6; g++) begin
         start_game();
         for (int r = 0; r < 10 && !m_over; r++) begin
            int k;
            k = $urandom_range(0, 3);
            do_round(k, (k == K_TIMEUP) ? $urandom_range(1, 4) : $urandom_range(0, 4));
         end
         while (!m_over) do_round(K_WRONG, $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid();
      start_game();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_score = 0; m_lives = c_L; m_over = 1'b0;
      n_checks++;
      if (w_obs !== exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++; $display("FAIL reset_mid: got %h exp %h", w_obs, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      start_game();
      do_round(K_CORRECT, 1);
   endtask

   initial begin
      test_reset();
      start_game();
      test_carry();
      test_saturation();
      test_lives();
      test_collision();
      test_wrong_submit();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
